// File: rtl/tt_pwm_bank_if.sv
// tt_pwm_bank_if: Tiny Tapeout style pin bundle for the PWM bank.
// The host side drives the dedicated inputs and the uio data byte.
// The project side drives the PWM outputs and the optional readback byte.
interface tt_pwm_bank_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_pwm_bank.sv
// tt_pwm_bank: bank of CHANNELS PWM outputs with double-buffered duty
// registers and a shared prescaler, configured over the Tiny Tapeout pins.
// Optional register readback over uio is built when TT_PWM_READBACK_EN is
// defined; otherwise uio_out and uio_oe are held at zero.
//
// Write handshake: the host sets ui_in[6:0] and uio_in, then raises
// ui_in[7]. It keeps everything stable for at least 3 cycles around the
// strobe, and drops the strobe before starting the next write. Each rising
// edge of the synchronised strobe gives exactly one write pulse. There is
// no back-pressure.
module tt_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRE_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    tt_pwm_bank_if.slave bus
);

    logic [2:0]          strobe_sync;
    logic                wr_edge;
    logic                rd_req;
    logic                wr_pulse;
    logic                wr_duty;
    logic                wr_pre;
    logic [2:0]          addr;
    logic [PRE_W-1:0]    prescale;
    logic [PRE_W-1:0]    pcnt;
    logic                tick;
    logic [WIDTH-1:0]    cnt;
    logic                wrap;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [CHANNELS-1:0] pwm_q;
    logic [7:0]          uo_val;
    logic                unused_ok;

    assign addr    = bus.ui_in[2:0];
    assign wr_edge = strobe_sync[1] & ~strobe_sync[2];

`ifdef TT_PWM_READBACK_EN
    assign rd_req = bus.ui_in[5];
`else
    assign rd_req = 1'b0;
`endif

    // A read request blocks writes, but the strobe is still synchronised.
    assign wr_pulse = ena & wr_edge & ~rd_req;
    assign wr_duty  = wr_pulse & ~bus.ui_in[6] & (32'(addr) < CHANNELS);
    assign wr_pre   = wr_pulse & bus.ui_in[6];

    assign tick = ena & (pcnt == prescale);
    assign wrap = tick & (cnt == '1);

    // Strobe synchroniser (two flops) plus the edge-detect flop; frozen while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_sync <= '0;
        end else if (ena) begin
            strobe_sync <= {strobe_sync[1:0], bus.ui_in[7]};
        end
    end

    // Prescale register and tick counter; a prescale write restarts the tick phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            pcnt     <= '0;
        end else if (wr_pre) begin
            prescale <= bus.uio_in[PRE_W-1:0];
            pcnt     <= '0;
        end else if (ena) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

    // Period counter advances once per tick and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Duty double buffer: the host writes shadow, and the wrap copies shadow to active.
    // A write on the wrap edge lands in shadow only, because active takes the old shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                shadow[n] <= '0;
                active[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (wrap) begin
                    active[n] <= shadow[n];
                end
                if (wr_duty && (addr == 3'(n))) begin
                    shadow[n] <= bus.uio_in[WIDTH-1:0];
                end
            end
        end
    end

    // Registered PWM compare, forced low while the project is deselected.
    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            pwm_q <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                pwm_q[n] <= (cnt < active[n]);
            end
        end
    end

    // Place the channel outputs in the low bits of uo_out and tie the spare bits low.
    always_comb begin
        uo_val                 = '0;
        uo_val[CHANNELS-1:0]   = pwm_q;
    end

    assign bus.uo_out = uo_val;

`ifdef TT_PWM_READBACK_EN
    logic [7:0] rd_val;
    logic [7:0] rb_data;
    logic [7:0] rb_oe;

    // Select the readback source: prescale, or the active duty of the addressed channel.
    always_comb begin
        rd_val = '0;
        if (bus.ui_in[6]) begin
            rd_val[PRE_W-1:0] = prescale;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (addr == 3'(n)) begin
                    rd_val[WIDTH-1:0] = active[n];
                end
            end
        end
    end

    // Registered readback data and drive enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_data <= '0;
            rb_oe   <= '0;
        end else if (ena && rd_req) begin
            rb_data <= rd_val;
            rb_oe   <= 8'hFF;
        end else begin
            rb_data <= '0;
            rb_oe   <= '0;
        end
    end

    assign bus.uio_out = rb_data;
    assign bus.uio_oe  = rb_oe;
`else
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;
`endif

    // Pins that carry no function in some configurations.
    assign unused_ok = ^{bus.ui_in, bus.uio_in};

endmodule

// File: tb/tb_tt_pwm_bank.sv
// tb_tt_pwm_bank: randomized self-checking bench for tt_pwm_bank.
// The reference model keeps only the programmed duty and prescale values.
// PWM is periodic, so the high count over any window of k whole periods must
// equal k * duty * (prescale+1) for each channel.
module tb_tt_pwm_bank;
    localparam int CH = 4;
    localparam int W  = 8;

    logic clk;
    logic rst;
    logic ena;
    tt_pwm_bank_if bus ();

    int checks = 0;
    int passed = 0;
    int duty_m [CH];
    int pre_m;

    tt_pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period_len();
        return (1 << W) * (pre_m + 1);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) duty_m[c] = 0;
        pre_m = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ena = 1'b0; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0; ena = 1'b1;
        model_reset();
    endtask

    // One host write: set up, raise the strobe, hold it, then drop it.
    task automatic write(input bit tgt, input int a, input int data);
        @(negedge clk);
        bus.ui_in  = {1'b0, tgt, 1'b0, 2'b00, 3'(a)};
        bus.uio_in = 8'(data);
        @(negedge clk);
        bus.ui_in[7] = 1'b1;
        repeat (4) @(negedge clk);
        bus.ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        if (tgt) pre_m = data & 8'hFF;
        else if (a < CH) duty_m[a] = data & ((1 << W) - 1);
    endtask

    task automatic settle();
        repeat (2 * period_len() + 8) @(negedge clk);
    endtask

    // Count highs over whole periods and compare each channel with the model.
    task automatic measure(input string name, input int periods);
        int hi [CH];
        int spare;
        int len;
        int exp_v;
        len = periods * period_len();
        spare = 0;
        for (int c = 0; c < CH; c++) hi[c] = 0;
        repeat (len) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (bus.uo_out[c]) hi[c]++;
            if (bus.uo_out[7:CH] != '0) spare++;
        end
        for (int c = 0; c < CH; c++) begin
            exp_v = periods * duty_m[c] * (pre_m + 1);
            checks++;
            if (hi[c] !== exp_v)
                $display("FAIL %s ch%0d high count: got %0d expected %0d", name, c, hi[c], exp_v);
            else passed++;
        end
        checks++;
        if (spare !== 0) $display("FAIL %s spare uo bits: got %0d high cycles expected 0", name, spare);
        else passed++;
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        rst = 1'b1; ena = 1'b1; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (bus.uo_out !== 8'h00) $display("FAIL reset uo_out: got %h expected 00", bus.uo_out); else passed++;
        checks++; if (bus.uio_oe !== 8'h00) $display("FAIL reset uio_oe: got %h expected 00", bus.uio_oe); else passed++;
        checks++; if (bus.uio_out !== 8'h00) $display("FAIL reset uio_out: got %h expected 00", bus.uio_out); else passed++;
        rst = 1'b0;
        model_reset();
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus.uo_out !== 8'h00 || bus.uio_oe !== 8'h00) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL idle outputs: got %0d nonzero cycles expected 0", bad);
        else passed++;
    endtask

    task automatic test_defaults();
        write(1'b0, 0, 64);
        write(1'b1, 0, 0);
        settle();
        for (int p = 0; p < 3; p++) measure("defaults", 1);
    endtask

    task automatic test_mid_period();
        int hi;
        do_reset();
        repeat (95) @(negedge clk);
        write(1'b0, 2, 200);
        hi = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.uo_out[2]) hi++;
        end
        checks++;
        if (hi !== 0) $display("FAIL mid_period old duty: got %0d high cycles expected 0", hi);
        else passed++;
        repeat (10) @(negedge clk);
        measure("mid_period_new", 2);
    endtask

    task automatic test_prescale();
        write(1'b0, 1, 128);
        write(1'b1, 0, 3);
        settle();
        measure("prescale3", 1);
        write(1'b0, 5, 17);
        settle();
        measure("addr_out_of_range", 1);
    endtask

    task automatic test_ena();
        int hi [CH];
        int bad;
        int len;
        int exp_v;
        len = period_len() + 50;
        bad = 0;
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (bus.uo_out[c]) hi[c]++;
            if (i > 300 && i <= 350 && bus.uo_out !== 8'h00) bad++;
            if (i == 300) ena = 1'b0;
            if (i == 350) ena = 1'b1;
        end
        checks++;
        if (bad !== 0) $display("FAIL ena_low outputs: got %0d nonzero cycles expected 0", bad);
        else passed++;
        for (int c = 0; c < CH; c++) begin
            exp_v = duty_m[c] * (pre_m + 1);
            checks++;
            if (hi[c] !== exp_v)
                $display("FAIL ena_pause ch%0d high count: got %0d expected %0d", c, hi[c], exp_v);
            else passed++;
        end
    endtask

    task automatic test_random();
        int d [CH];
        for (int r = 0; r < 4; r++) begin
            if (r == 0) begin
                d[0] = 0; d[1] = 255; d[2] = 1; d[3] = 128;
            end else begin
                for (int c = 0; c < CH; c++) d[c] = $urandom_range(0, 255);
            end
            for (int c = 0; c < CH; c++) write(1'b0, c, d[c]);
            write(1'b1, 0, (r == 0) ? 0 : $urandom_range(0, 2));
            settle();
            measure("random", 1);
        end
    endtask

`ifdef TT_PWM_READBACK_EN
    task automatic test_readback();
        logic [7:0] exp_b;
        write(1'b0, 3, 8'hA5);
        settle();
        @(negedge clk); bus.ui_in = 8'h23;
        repeat (2) @(negedge clk);
        checks++; if (bus.uio_oe !== 8'hFF) $display("FAIL readback oe: got %h expected ff", bus.uio_oe); else passed++;
        checks++; if (bus.uio_out !== 8'hA5) $display("FAIL readback ch3: got %h expected a5", bus.uio_out); else passed++;
        bus.ui_in = 8'hA3; bus.uio_in = 8'h11;
        repeat (5) @(negedge clk);
        bus.ui_in = 8'h23;
        settle();
        checks++; if (bus.uio_out !== 8'hA5) $display("FAIL readback after suppressed write: got %h expected a5", bus.uio_out); else passed++;
        measure("suppressed_write", 1);
        @(negedge clk); bus.ui_in = 8'h63;
        repeat (2) @(negedge clk);
        exp_b = 8'(pre_m);
        checks++; if (bus.uio_out !== exp_b) $display("FAIL readback prescale: got %h expected %h", bus.uio_out, exp_b); else passed++;
        bus.ui_in = 8'h25;
        repeat (2) @(negedge clk);
        checks++; if (bus.uio_out !== 8'h00) $display("FAIL readback addr5: got %h expected 00", bus.uio_out); else passed++;
        bus.ui_in = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bus.uio_oe !== 8'h00) $display("FAIL readback release oe: got %h expected 00", bus.uio_oe); else passed++;
    endtask
`else
    task automatic test_readback();
        @(negedge clk); bus.ui_in = 8'h23;
        repeat (2) @(negedge clk);
        checks++; if (bus.uio_oe !== 8'h00) $display("FAIL no_readback oe: got %h expected 00", bus.uio_oe); else passed++;
        checks++; if (bus.uio_out !== 8'h00) $display("FAIL no_readback out: got %h expected 00", bus.uio_out); else passed++;
        bus.ui_in = 8'h00;
    endtask
`endif

    task automatic test_reset_mid_write();
        @(negedge clk);
        bus.ui_in = 8'h00; bus.uio_in = 8'd77;
        @(negedge clk); bus.ui_in[7] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); bus.ui_in[7] = 1'b0;
        @(negedge clk);
        checks++; if (bus.uo_out !== 8'h00) $display("FAIL reset_mid uo_out: got %h expected 00", bus.uo_out); else passed++;
        rst = 1'b0;
        model_reset();
        settle();
        measure("reset_mid_write", 1);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
        model_reset();
        test_reset();
        test_defaults();
        test_mid_period();
        test_prescale();
        test_ena();
        test_random();
        test_readback();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tt_pwm_bank.md
Name: tt_pwm_bank

Overview:
- Parametrised successor to the single-function Tiny Tapeout user top. It uses the same eight-bit `ui`/`uo`/`uio` pin contract and replaces one fixed behaviour with a bank of configurable PWM channels.
- Configuration is written over the dedicated inputs and the `uio` data byte.
- Each channel has a double-buffered duty register. A shared prescaler sets the PWM period.
- Sits directly under the chip-level wrapper as the selected user project.

Parameters:
- CHANNELS, 4: number of PWM channels, legal range 1..8; channel n drives uo_out[n].
- WIDTH, 8: duty and period counter width, legal range 4..8; the period is 2^WIDTH prescaled ticks.
- PRE_W, 8: prescaler register width; tick rate = clk / (prescale+1).

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  design enable; high when the project is selected.
- ui_in  in  8  [7]=write strobe, [6]=target select (0=duty, 1=prescale), [5]=read request, [2:0]=channel address.
- uio_in  in  8  write data byte.
- uo_out  out  8  [CHANNELS-1:0]=PWM outputs; unused bits are 0.
- uio_out  out  8  readback data; 0 when unused.
- uio_oe  out  8  uio direction; 1 = output.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset rst is synchronous and active-high.
  - At reset: all outputs are 0; duty shadow and active registers are 0; prescale is 0; prescale counter is 0; period counter is 0; synchroniser flops are 0.
- Strobe input path:
  - ui_in[7] passes through a 2-flop synchroniser followed by a third flop for edge detection.
  - A rising edge produces a one-cycle write pulse, asserted 2 clk edges after the first edge that samples the strobe high.
  - ui_in[6:0] and uio_in are sampled on the edge at which the write pulse is asserted. The host holds them stable for 3 or more cycles around the strobe.
  - A level-high strobe produces exactly one write. The strobe must return low before the next write is accepted.
- Duty write (ui_in[6]=0):
  - shadow[addr] <= uio_in[WIDTH-1:0]; the upper bits are discarded.
  - addr >= CHANNELS: the write is ignored and no state changes.
- Prescale write (ui_in[6]=1):
  - prescale <= uio_in[PRE_W-1:0].
  - The prescale counter is cleared to 0 on the same edge.
  - The period counter is not touched.
- Prescaler:
  - pcnt counts 0..prescale.
  - tick = (pcnt == prescale); pcnt wraps to 0 on tick.
  - prescale=0 gives tick every cycle.
- Period counter:
  - cnt is WIDTH bits and advances by 1 on each tick.
  - It wraps from 2^WIDTH-1 to 0.
- Double buffering:
  - On the tick where cnt wraps to 0, active[n] <= shadow[n] for all channels simultaneously.
  - A write landing on the same edge as the load is captured in shadow only. It becomes active at the next wrap.
- Outputs:
  - uo_out[n] is registered as (cnt < active[n]), so it is valid one clk after cnt changes.
  - duty 0 gives constant low.
  - duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH ticks; 100% duty is not reachable.
- ena low:
  - pcnt, cnt and the write path hold their values.
  - uo_out is forced to 0 on the next edge.
  - When ena returns high, counting resumes from the held values.
- Reset asserted mid-period or mid-write: all state returns to its reset values on that edge, and any pending write is discarded.
- Without the optional feature: uio_oe = 8'h00 and uio_out = 8'h00 constant.

Optional Feature:
- Macro: TT_PWM_READBACK_EN.
- Defined:
  - While ui_in[5]=1 and ena=1, uio_oe = 8'hFF on the next edge.
  - uio_out shows the selected value, zero-extended and registered:
    - ui_in[6]=0: active duty of channel ui_in[2:0].
    - ui_in[6]=1: prescale.
  - Channel address >= CHANNELS reads 8'h00.
  - While ui_in[5]=1, writes are suppressed: the strobe is still synchronised, but the pulse is ignored.
  - When ui_in[5]=0, uio_oe returns to 8'h00 on the next edge.
- Undefined: the readback logic is not built and uio_oe and uio_out are constant 0.

Test Plan:
- Reset, then ena=1, with no writes for 600 cycles -> uo_out==8'h00 throughout; uio_oe==8'h00.
- Defaults. Write duty ch0=64 and prescale=0, then run 3 periods -> after the first wrap, uo_out[0] is high exactly 64 of every 256 cycles.
- Write ch2=200 mid-period, when cnt=100 -> the current period keeps the old duty (0). From the next wrap, high is 200 of 256.
- Write prescale=3 with ch1=128 -> the period is 1024 clk and uo_out[1] is high for 512. Write addr 5 with CHANNELS=4 -> no change on any output.
- ena dropped for 50 cycles mid-period -> uo_out is 0 during that time. cnt resumes from its held value, and the total high time of the interrupted period equals duty*(prescale+1).
- With TT_PWM_READBACK_EN: after ch3=0xA5 is written and loaded, ui_in=8'h23 -> uio_oe==8'hFF and uio_out==8'hA5. Pulsing the strobe with ui_in[5]=1 changes nothing. With ui_in[6]=1 the readback returns the prescale value.
